// File: rtl/waveform_pkg.sv
// Shared definitions for the pulse-coded waveform path (generator and decoder).
package waveform_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DATA = 2'b01,
    STOP = 2'b10,
    ERR  = 2'b11
  } state_t;

  localparam int SYM_LEN = 3;

endpackage

// File: rtl/waveform_word_assembler.sv
// Collects decoded bits MSB-first into WIDTH-bit words and publishes each complete word.
module waveform_word_assembler
  import waveform_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic             clear,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shifted;
  logic [CNT_W-1:0] bit_cnt;

  assign shifted = {shift_reg[WIDTH-2:0], bit_in};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (clear) begin
        // A malformed symbol throws away whatever part of the word was gathered.
        shift_reg <= '0;
        bit_cnt   <= '0;
      end else if (shift_en) begin
        shift_reg <= shifted;
        if (bit_cnt == CNT_W'(WIDTH - 1)) begin
          bit_cnt    <= '0;
          data_out   <= shifted;
          data_valid <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/waveform_decoder.sv
// Samples the pulse-coded line, decodes 3-sample symbols (1,b,0) into bits and words.
module waveform_decoder
  import waveform_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  output logic             bit_out,
  output logic             bit_valid,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             frame_err
);

  state_t state;
  state_t next_state;
  logic   capture;
  logic   shift_en;
  logic   clear;
  logic   cand;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (enable) begin
      case (state)
        IDLE:    if (sig_in) next_state = DATA;
        DATA:    next_state = STOP;
        STOP:    next_state = sig_in ? ERR : IDLE;
        ERR:     if (!sig_in) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    capture  = 1'b0;
    shift_en = 1'b0;
    clear    = 1'b0;
    if (enable) begin
      case (state)
        DATA:    capture = 1'b1;
        STOP:    if (sig_in) clear = 1'b1; else shift_en = 1'b1;
        default: ;
      endcase
    end
  end

  // Registered outputs; pulses fall on the following edge whether or not enable is set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand      <= 1'b0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      bit_valid <= shift_en;
      frame_err <= clear;
      if (capture)  cand    <= sig_in;
      if (shift_en) bit_out <= cand;
    end
  end

  waveform_word_assembler #(.WIDTH(WIDTH)) u_assembler (
    .clk        (clk),
    .reset      (reset),
    .shift_en   (shift_en),
    .bit_in     (cand),
    .clear      (clear),
    .data_out   (data_out),
    .data_valid (data_valid)
  );

endmodule

// File: doc/waveform_decoder.md
# waveform_decoder

Serial waveform receiver: samples a single-wire pulse-coded line, decodes each 3-cycle symbol into one data bit, and assembles bits MSB-first into WIDTH-bit words. It sits at the far end of the waveform generator path and recovers the bit stream that the transmitter encoded onto the line. The block flags malformed symbols and discards any partial word when it does.

## Interface
- WIDTH, 8, word length in bits (≥2)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state and outputs
- enable  input  1  sample qualifier; sig_in is only sampled on edges where enable=1
- sig_in  input  1  encoded line, synchronous to clk, idle low
- bit_out  output  1  most recently decoded bit
- bit_valid  output  1  one-clk pulse, one per good symbol
- data_out  output  WIDTH  last complete word, MSB = first received bit
- data_valid  output  1  one-clk pulse when data_out updates
- frame_err  output  1  one-clk pulse on a malformed symbol

## Operation
- Symbol format: three consecutive enabled samples, start=1, data=b, stop=0. Logic 1 encodes as 1,1,0. Logic 0 encodes as 1,0,0. Any number of idle-low samples may sit between symbols.
- FSM states: IDLE, DATA, STOP, ERR.
- IDLE: if sig_in=1, go to DATA. Otherwise stay in IDLE.
- DATA: capture sig_in as the candidate bit, then go to STOP.
- STOP, sig_in=0:
  - Symbol is good: bit_out gets the candidate, bit_valid pulses.
  - The bit shifts into the word register at the LSB, with the earlier bits moving toward the MSB.
  - The bit counter increments and the FSM returns to IDLE.
- STOP, sig_in=1:
  - frame_err pulses.
  - The bit counter clears and the partial word is discarded; data_out is unchanged.
  - The FSM goes to ERR.
- ERR: stay until sig_in=0 is sampled, then go to IDLE. A line stuck high therefore produces exactly one frame_err.
- Word completion: when the WIDTH-th good bit lands (counter = WIDTH-1):
  - data_out loads the full word.
  - data_valid pulses in the same cycle as that bit's bit_valid.
  - The counter wraps to 0.
- data_out holds its value until the next complete word.
- enable=0: the FSM, counter and shift register all hold. No sample is taken and a symbol in progress is not aborted.
- Reset values: state=IDLE, counter=0, shift register=0, bit_out=0, bit_valid=0, data_out=0, data_valid=0, frame_err=0.

## Timing
- All outputs are registered. Pulse outputs are high for exactly one clk cycle, cleared on the next clk edge regardless of enable.
- Latency (enable held high): start sampled at edge k, data at k+1, stop at k+2. bit_valid/data_valid/frame_err are high in the cycle after edge k+2.
- Back-to-back symbols need no idle gap: a 1 sampled in IDLE immediately after a good stop begins the next symbol. Minimum symbol period is 3 enabled samples.
- Reset mid-symbol or mid-word: state returns to IDLE asynchronously. Partial bits are lost and no pulse is emitted.
- Simultaneous completion: a frame error can never coincide with data_valid. The WIDTH-th bit is counted only on a good stop.

## Structure
- Shared package waveform_pkg holds:
  - the 2-bit state encoding constants: IDLE=2'b00, DATA=2'b01, STOP=2'b10, ERR=2'b11;
  - the symbol length constant SYM_LEN=3.
- The transmitter-side generator uses the same package.
- One sub-module: waveform_word_assembler. It holds the WIDTH-bit shift register, the bit counter of $clog2(WIDTH) bits, the data_out register and the data_valid generation.
- Its inputs are shift_en, bit_in and clear, all driven by the top-level FSM.

## Test plan
- Reset, then with enable=1 send the 24-sample symbol stream for 8'hA5 (1,1,0,1,0,0,...) → eight bit_valid pulses with bit_out sequence 1,0,1,0,0,1,0,1. data_out=8'hA5 and data_valid coincide with the 8th bit_valid. frame_err stays 0.
- Send 8'h3C with 0–5 random idle-low samples between symbols, then 8'hFF back-to-back → data_valid twice, data_out=8'h3C then 8'hFF.
- Send 3 good bits, then a symbol 1,1,1, then hold high for 4 samples, then low, then a full 8'h81 → one frame_err pulse only. The partial word is discarded. The next data_valid shows 8'h81, not a mix.
- Toggle enable low for 2 cycles inside the DATA and STOP phases while sending 8'h5A, holding sig_in at junk values while disabled → decode is identical to the no-stall case, data_out=8'h5A.
- Assert reset after 5 good bits, mid-symbol, then send 8'hC3 → all outputs read 0 during reset. No pulse is emitted for the aborted symbol. Next data_out=8'hC3.
- Hold sig_in=0 for 100 cycles after reset → no pulses, and all outputs stay at their reset values.
